// File: rtl/jac_pkg.sv
// Shared definitions for the JAC sequencer: widths, opcodes, status bits,
// instruction field positions and FSM state encodings.
package jac_pkg;

    localparam int JAC_DATA_W   = 8;
    localparam int JAC_OPC_W    = 5;
    localparam int JAC_PARAM_W  = 8;
    localparam int JAC_STATUS_W = 6;
    localparam int JAC_PC_W     = 8;
    localparam int JAC_INSTR_W  = 20;

    // ALU opcodes
    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_NOT  = 5'h05;
    localparam logic [4:0] OP_XOR  = 5'h06;
    localparam logic [4:0] OP_SHL  = 5'h07;
    localparam logic [4:0] OP_SHR  = 5'h08;
    localparam logic [4:0] OP_VAL  = 5'h09;
    localparam logic [4:0] OP_CMP  = 5'h0A;

    // Control opcodes
    localparam logic [4:0] OP_JMP  = 5'h10;
    localparam logic [4:0] OP_JZ   = 5'h11;
    localparam logic [4:0] OP_JC   = 5'h12;
    localparam logic [4:0] OP_JEQ  = 5'h13;
    localparam logic [4:0] OP_JGT  = 5'h14;
    localparam logic [4:0] OP_JLT  = 5'h15;
    localparam logic [4:0] OP_HALT = 5'h1F;

    // Status bit indices
    localparam int ST_CARRY     = 0;
    localparam int ST_UNDERFLOW = 1;
    localparam int ST_ZERO      = 2;
    localparam int ST_EQUAL     = 3;
    localparam int ST_GREATER   = 4;
    localparam int ST_SMALLER   = 5;

    // Instruction field positions
    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 15;
    localparam int RD_MSB  = 14;
    localparam int RD_LSB  = 13;
    localparam int RS_MSB  = 12;
    localparam int RS_LSB  = 11;
    localparam int RSV_MSB = 10;
    localparam int RSV_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // FSM states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

endpackage

// File: rtl/jac_regfile.sv
// 4-entry register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port.
module jac_regfile
    import jac_pkg::*;
#(
    parameter int DataWidth = JAC_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [1:0]           waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [1:0]           raddr_a,
    input  logic [1:0]           raddr_b,
    input  logic [1:0]           dbg_sel,
    output logic [DataWidth-1:0] rdata_a,
    output logic [DataWidth-1:0] rdata_b,
    output logic [DataWidth-1:0] dbg_data
);

    logic [DataWidth-1:0] regs [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/jac_sequencer.sv
// Three-cycle FETCH/DECODE/EXECUTE sequencer driving an external ALU_J,
// with a synchronous program ROM addressed by pc.
module jac_sequencer
    import jac_pkg::*;
#(
    parameter int DataWidth     = JAC_DATA_W,
    parameter int NumOpCodeBits = JAC_OPC_W,
    parameter int ParamBits     = JAC_PARAM_W,
    parameter int NumStatusBits = JAC_STATUS_W,
    parameter int PcBits        = JAC_PC_W,
    parameter int InstrBits     = JAC_INSTR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [PcBits-1:0]        pc,
    input  logic [InstrBits-1:0]     instr,
    output logic [NumOpCodeBits-1:0] alu_opcode,
    output logic [DataWidth-1:0]     alu_operand1,
    output logic [DataWidth-1:0]     alu_operand2,
    output logic [ParamBits-1:0]     alu_param,
    input  logic [DataWidth-1:0]     alu_result,
    input  logic [NumStatusBits-1:0] alu_status,
    output logic [NumStatusBits-1:0] flags,
    output logic                     busy,
    output logic                     halted,
    output logic                     illegal,
    input  logic [1:0]               dbg_sel,
    output logic [DataWidth-1:0]     dbg_data
);

    logic [2:0]               state;
    logic [InstrBits-1:0]     ir;
    logic [NumOpCodeBits-1:0] ir_opc;
    logic [1:0]               ir_rd;
    logic [1:0]               ir_rs;
    logic [ParamBits-1:0]     ir_imm;
    logic [DataWidth-1:0]     rdata_a;
    logic [DataWidth-1:0]     rdata_b;
    logic                     in_exec;
    logic                     op_alu_wr;
    logic                     op_cmp;
    logic                     op_nop;
    logic                     op_jump;
    logic                     op_halt;
    logic                     jump_taken;
    logic                     reg_we;
    logic                     unused_rsv;

    assign ir_opc     = ir[OPC_MSB:OPC_LSB];
    assign ir_rd      = ir[RD_MSB:RD_LSB];
    assign ir_rs      = ir[RS_MSB:RS_LSB];
    assign ir_imm     = ir[IMM_MSB:IMM_LSB];
    assign unused_rsv = ^ir[RSV_MSB:RSV_LSB];

    assign in_exec = (state == S_EXECUTE);
    assign busy    = (state == S_FETCH) || (state == S_DECODE) || in_exec;
    assign halted  = (state == S_HALT);

    always_comb begin
        op_alu_wr  = (ir_opc >= OP_ADD) && (ir_opc <= OP_VAL);
        op_cmp     = (ir_opc == OP_CMP);
        op_nop     = (ir_opc == OP_NOP);
        op_jump    = (ir_opc >= OP_JMP) && (ir_opc <= OP_JLT);
        op_halt    = (ir_opc == OP_HALT);
        // Conditions use flags as latched before this EXECUTE edge
        jump_taken = 1'b0;
        case (ir_opc)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = flags[ST_ZERO];
            OP_JC:   jump_taken = flags[ST_CARRY];
            OP_JEQ:  jump_taken = flags[ST_EQUAL];
            OP_JGT:  jump_taken = flags[ST_GREATER];
            OP_JLT:  jump_taken = flags[ST_SMALLER];
            default: jump_taken = 1'b0;
        endcase
    end

    assign reg_we = in_exec && op_alu_wr;

    assign alu_opcode   = in_exec ? ir_opc  : OP_NOP;
    assign alu_operand1 = in_exec ? rdata_a : '0;
    assign alu_operand2 = in_exec ? rdata_b : '0;
    assign alu_param    = in_exec ? ir_imm  : '0;

    jac_regfile #(
        .DataWidth (DataWidth)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (reg_we),
        .waddr    (ir_rd),
        .wdata    (alu_result),
        .raddr_a  (ir_rd),
        .raddr_b  (ir_rs),
        .dbg_sel  (dbg_sel),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            flags   <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state   <= S_FETCH;
                        pc      <= '0;
                        illegal <= 1'b0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= instr;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    // HALT and undefined opcodes leave pc on the offending address
                    if (op_alu_wr || op_cmp) begin
                        flags <= alu_status;
                    end
                    if (op_jump) begin
                        pc    <= jump_taken ? ir_imm : pc + 1'b1;
                        state <= S_FETCH;
                    end else if (op_alu_wr || op_cmp || op_nop) begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end else if (op_halt) begin
                        state <= S_HALT;
                    end else begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jac_sequencer.sv
// Directed bench for jac_sequencer with a synchronous program ROM and a
// behavioural ALU_J model wired around the DUT.
module tb_jac_sequencer;
    import jac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  pc;
    logic [19:0] instr;
    logic [4:0]  alu_opcode;
    logic [7:0]  alu_operand1;
    logic [7:0]  alu_operand2;
    logic [7:0]  alu_param;
    logic [7:0]  alu_result;
    logic [5:0]  alu_status;
    logic [5:0]  flags;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    logic [19:0] rom [256];
    logic [8:0]  sum;
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    bit          found;

    always #5 clk = ~clk;

    always @(posedge clk) instr <= rom[pc];

    // ALU_J model
    always_comb begin
        alu_result = '0;
        alu_status = '0;
        sum        = {1'b0, alu_operand1} + {1'b0, alu_operand2};
        case (alu_opcode)
            OP_ADD: begin alu_result = sum[7:0]; alu_status[ST_CARRY] = sum[8]; end
            OP_SUB: begin
                alu_result               = alu_operand1 - alu_operand2;
                alu_status[ST_UNDERFLOW] = alu_operand1 < alu_operand2;
                alu_status[ST_EQUAL]     = alu_operand1 == alu_operand2;
                alu_status[ST_GREATER]   = alu_operand1 > alu_operand2;
                alu_status[ST_SMALLER]   = alu_operand1 < alu_operand2;
            end
            OP_AND: alu_result = alu_operand1 & alu_operand2;
            OP_OR:  alu_result = alu_operand1 | alu_operand2;
            OP_NOT: alu_result = ~alu_operand1;
            OP_XOR: alu_result = alu_operand1 ^ alu_operand2;
            OP_SHL: begin alu_result = alu_operand1 << 1; alu_status[ST_CARRY] = alu_operand1[7]; end
            OP_SHR: alu_result = alu_operand1 >> 1;
            OP_VAL: alu_result = alu_param;
            OP_CMP: begin
                alu_status[ST_EQUAL]   = alu_operand1 == alu_operand2;
                alu_status[ST_GREATER] = alu_operand1 > alu_operand2;
                alu_status[ST_SMALLER] = alu_operand1 < alu_operand2;
            end
            default: ;
        endcase
        if (alu_opcode >= OP_ADD && alu_opcode <= OP_VAL)
            alu_status[ST_ZERO] = (alu_result == 8'h00);
    end

    jac_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pc           (pc),
        .instr        (instr),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_param    (alu_param),
        .alu_result   (alu_result),
        .alu_status   (alu_status),
        .flags        (flags),
        .busy         (busy),
        .halted       (halted),
        .illegal      (illegal),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    function automatic logic [19:0] enc(input logic [4:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, 3'b000, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = enc(OP_NOP, 0, 0, 0);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        check(tag, halted, 1'b1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        dbg_sel = 2'd0;
        rom_clear();

        // Reset held two cycles
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", pc, 8'h00);
        check("rst_flags", flags, 6'h00);
        check("rst_illegal", illegal, 1'b0);
        check("rst_alu_op", alu_opcode, OP_NOP);
        check_reg("rst_r0", 2'd0, 8'h00);

        // Program 1: carry out of ADD, JC taken, HALT at 0x20
        rom[0]    = enc(OP_VAL, 0, 0, 8'hFF);
        rom[1]    = enc(OP_VAL, 1, 0, 8'h02);
        rom[2]    = enc(OP_ADD, 0, 1, 8'h00);
        rom[3]    = enc(OP_JC,  0, 0, 8'h20);
        rom[4]    = enc(OP_HALT, 0, 0, 8'h00);
        rom[8'h20] = enc(OP_HALT, 0, 0, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        do_start();
        check("start_pc", pc, 8'h00);
        check("start_busy", busy, 1'b1);
        check("fetch_alu_op", alu_opcode, OP_NOP);
        check("fetch_alu_param", alu_param, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("exec_alu_op", alu_opcode, OP_VAL);
        check("exec_alu_param", alu_param, 8'hFF);
        @(negedge clk);
        check("seq_pc1", pc, 8'h01);
        check("seq_busy", busy, 1'b1);
        wait_halt("p1_halted");
        check("p1_pc", pc, 8'h20);
        check("p1_busy", busy, 1'b0);
        check("p1_carry", flags[ST_CARRY], 1'b1);
        check_reg("p1_r0", 2'd0, 8'h01);
        check_reg("p1_r1", 2'd1, 8'h02);
        repeat (3) @(negedge clk);
        check("p1_pc_hold", pc, 8'h20);

        // Program 2: SUB underflow, JLT taken to 0x40
        rom_clear();
        rom[0]     = enc(OP_VAL, 0, 0, 8'd14);
        rom[1]     = enc(OP_VAL, 1, 0, 8'd15);
        rom[2]     = enc(OP_SUB, 0, 1, 8'h00);
        rom[3]     = enc(OP_JLT, 0, 0, 8'h40);
        rom[4]     = enc(OP_HALT, 0, 0, 8'h00);
        rom[8'h40] = enc(OP_HALT, 0, 0, 8'h00);
        do_start();
        wait_halt("p2_halted");
        check("p2_pc", pc, 8'h40);
        check("p2_flags", flags, 6'b100010);
        check_reg("p2_r0", 2'd0, 8'hFF);

        // Program 3: CMP R2,R2 then JZ (not taken) and JEQ (taken)
        rom_clear();
        rom[0]     = enc(OP_VAL, 2, 0, 8'hF6);
        rom[1]     = enc(OP_CMP, 2, 2, 8'h00);
        rom[2]     = enc(OP_JZ,  0, 0, 8'h50);
        rom[3]     = enc(OP_JEQ, 0, 0, 8'h30);
        rom[4]     = enc(OP_HALT, 0, 0, 8'h00);
        rom[8'h30] = enc(OP_HALT, 0, 0, 8'h00);
        rom[8'h50] = enc(OP_HALT, 0, 0, 8'h00);
        do_start();
        wait_halt("p3_halted");
        check("p3_pc", pc, 8'h30);
        check("p3_flags", flags, 6'b001000);
        check_reg("p3_r2", 2'd2, 8'hF6);

        // Program 4: undefined opcode 0x0B at pc 5
        rom_clear();
        rom[5] = enc(5'h0B, 0, 1, 8'h77);
        do_start();
        wait_halt("p4_halted");
        check("p4_illegal", illegal, 1'b1);
        check("p4_pc", pc, 8'h05);
        check("p4_flags", flags, 6'b001000);
        check_reg("p4_r0", 2'd0, 8'hFF);
        do_start();
        check("p4_restart_illegal", illegal, 1'b0);
        check("p4_restart_pc", pc, 8'h00);
        wait_halt("p4_halted2");

        // Program 5: reset in the middle of an ADD EXECUTE
        rom_clear();
        rom[0] = enc(OP_ADD, 3, 1, 8'h00);
        do_start();
        @(negedge clk);
        @(negedge clk);
        check("p5_exec_op", alu_opcode, OP_ADD);
        check("p5_exec_opnd1", alu_operand1, 8'h00);
        check("p5_exec_opnd2", alu_operand2, 8'd15);
        rst_n = 1'b0;
        @(negedge clk);
        check("p5_busy", busy, 1'b0);
        check("p5_halted", halted, 1'b0);
        check("p5_pc", pc, 8'h00);
        check("p5_flags", flags, 6'h00);
        check("p5_alu_op", alu_opcode, OP_NOP);
        check_reg("p5_r3", 2'd3, 8'h00);
        check_reg("p5_r1", 2'd1, 8'h00);

        // Straight-line NOPs run off the end of the ROM and wrap
        rom_clear();
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (pc == 8'hFF) found = 1'b1;
        end
        check("wrap_reach_ff", found, 1'b1);
        repeat (3) @(negedge clk);
        check("wrap_pc", pc, 8'h00);
        check("wrap_busy", busy, 1'b1);
        check("wrap_illegal", illegal, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
